// File: rtl/uart_rx.sv
// +----------------------------------------------------------------------------+
// | uart_rx : 8-bit UART receiver, 16x oversampling, parity, held output.      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       serial_in,
  input  logic       parity_odd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       sync_meta;
  logic       sync_rx;
  logic       prev_rx;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       parity_bit;
  logic       frame_done;
  logic       mid_tick;
  logic       end_tick;
  logic       frame_parity_err;

  assign mid_tick         = baud_tick && (tick_cnt == 4'd7);
  assign end_tick         = baud_tick && (tick_cnt == 4'd15);
  assign frame_parity_err = (^shift ^ parity_odd) != parity_bit;
  assign rx_busy          = (state != IDLE);

  // prev_rx also resets high so a line already idle never looks like an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_rx   <= 1'b1;
      prev_rx   <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      sync_rx   <= sync_meta;
      prev_rx   <= sync_rx;
    end
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (prev_rx && !sync_rx) state_next = START;
      START:  if (mid_tick) state_next = sync_rx ? IDLE : DATA;
      DATA:   if (end_tick && (bit_idx == 3'd7)) state_next = PARITY;
      PARITY: if (end_tick) state_next = STOP;
      STOP: begin
        if (end_tick) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      parity_bit <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        tick_cnt <= 4'd0;
      end else if (baud_tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
      if ((state == START) && (state_next == DATA)) begin
        bit_idx <= 3'd0;
      end
      if ((state == DATA) && end_tick) begin
        shift   <= {sync_rx, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if ((state == PARITY) && end_tick) begin
        parity_bit <= sync_rx;
      end
    end
  end

  // A completing frame is only accepted if the held byte is free or leaving now
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (frame_done) begin
      if (!rx_valid || rx_ready) begin
        rx_data     <= shift;
        rx_valid    <= 1'b1;
        parity_err  <= frame_parity_err;
        frame_err   <= !sync_rx;
        overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +----------------------------------------------------------------------------+
// | tb_uart_rx : directed scoreboard bench for uart_rx.                        |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic       serial_in;
  logic       parity_odd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   tick_seen = 0;

  uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .serial_in   (serial_in),
    .parity_odd  (parity_odd),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One baud_tick every 4 clocks, so one bit time is 64 clocks
  initial begin : g_baud
    int ph;
    ph = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      baud_tick = (ph == 0);
    end
  end

  initial begin : g_tick_count
    forever begin
      @(posedge clk);
      if (baud_tick) tick_seen++;
    end
  end

  initial begin : g_watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      serial_in = bits[i];
      repeat (64) step();
    end
  endtask

  function automatic logic calc_parity(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 8'(exp_q.size() != 0), 8'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 8'(rx_valid), 8'd1);
      check({tag, "_data"}, rx_data, e.data);
      check({tag, "_perr"}, 8'(parity_err), 8'(e.perr));
      check({tag, "_ferr"}, 8'(frame_err), 8'(e.ferr));
    end
  endtask

  task automatic consume(input string tag);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check({tag, "_cons_valid"}, 8'(rx_valid), 8'd0);
    check({tag, "_cons_ovr"}, 8'(overrun_err), 8'd0);
    check({tag, "_cons_perr"}, 8'(parity_err), 8'd0);
    check({tag, "_cons_ferr"}, 8'(frame_err), 8'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, rx_data, 8'h00);
    check({tag, "_valid"}, 8'(rx_valid), 8'd0);
    check({tag, "_perr"}, 8'(parity_err), 8'd0);
    check({tag, "_ferr"}, 8'(frame_err), 8'd0);
    check({tag, "_ovr"}, 8'(overrun_err), 8'd0);
    check({tag, "_busy"}, 8'(rx_busy), 8'd0);
  endtask

  initial begin : g_main
    reset      = 1'b1;
    serial_in  = 1'b1;
    parity_odd = 1'b0;
    rx_ready   = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (70) step();

    // Clean frame, even parity
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, calc_parity(8'hA5, 1'b0), 1'b1);
    check_frame("clean_a5");
    check("clean_a5_ovr", 8'(overrun_err), 8'd0);
    check("clean_a5_busy", 8'(rx_busy), 8'd0);
    consume("clean_a5");

    // Parity error: odd parity wants 1, line carries 0
    parity_odd = 1'b1;
    push_exp(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    check_frame("perr_3c");
    consume("perr_3c");
    parity_odd = 1'b0;

    // Frame error followed by a 40-bit break
    push_exp(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, calc_parity(8'h55, 1'b0), 1'b0);
    repeat (40 * 64) step();
    check("break_busy", 8'(rx_busy), 8'd0);
    check("break_ovr", 8'(overrun_err), 8'd0);
    check_frame("ferr_55");
    serial_in = 1'b1;
    repeat (128) step();
    check("break_end_ovr", 8'(overrun_err), 8'd0);
    check("break_end_busy", 8'(rx_busy), 8'd0);
    consume("ferr_55");

    // Overrun: second frame dropped while the first is held
    push_exp(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, calc_parity(8'h11, 1'b0), 1'b1);
    send_frame(8'h22, calc_parity(8'h22, 1'b0), 1'b1);
    check("ovr_flag", 8'(overrun_err), 8'd1);
    check_frame("ovr_11");
    consume("ovr");

    // Short low glitch is a false start
    serial_in = 1'b0;
    repeat (8) step();
    check("glitch_busy", 8'(rx_busy), 8'd1);
    repeat (8) step();
    serial_in = 1'b1;
    repeat (128) step();
    check("glitch_idle", 8'(rx_busy), 8'd0);
    check("glitch_valid", 8'(rx_valid), 8'd0);

    // Reset in the middle of data bit 4
    begin : g_mid_reset
      logic [7:0] d;
      d = 8'hC3;
      serial_in = 1'b0;
      repeat (64) step();
      for (int i = 0; i < 4; i++) begin
        serial_in = d[i];
        repeat (64) step();
      end
      serial_in = d[4];
      repeat (16) step();
      check("midrst_busy", 8'(rx_busy), 8'd1);
      reset = 1'b1;
      serial_in = 1'b1;
      repeat (2) step();
      check_reset_outputs("midrst");
      reset = 1'b0;
      repeat (64 * 8) step();
      check("midrst_no_valid", 8'(rx_valid), 8'd0);
      check("midrst_no_busy", 8'(rx_busy), 8'd0);
    end
    push_exp(8'h0F, 1'b0, 1'b0);
    send_frame(8'h0F, calc_parity(8'h0F, 1'b0), 1'b1);
    check_frame("after_rst_0f");
    consume("after_rst_0f");

    // New frame completes on the very cycle the held byte is consumed
    push_exp(8'h7F, 1'b0, 1'b0);
    send_frame(8'h7F, calc_parity(8'h7F, 1'b0), 1'b1);
    check_frame("held_7f");
    push_exp(8'h80, 1'b0, 1'b0);
    fork
      send_frame(8'h80, calc_parity(8'h80, 1'b0), 1'b1);
      begin : g_sim_watch
        int n;
        int base;
        n = 0;
        while (!rx_busy && n < 400) begin
          step();
          n++;
        end
        check("sim_busy_seen", 8'(rx_busy), 8'd1);
        base = tick_seen;
        n = 0;
        // 8 start + 128 data + 16 parity + 16 stop ticks: completion on tick 168
        while (!((tick_seen == base + 167) && baud_tick) && n < 2000) begin
          step();
          n++;
        end
        check("sim_tick_reached", 8'(n < 2000), 8'd1);
        check("sim_prev_held", rx_data, 8'h7F);
        check("sim_prev_valid", 8'(rx_valid), 8'd1);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("sim_latency_valid", 8'(rx_valid), 8'd1);
        check("sim_latency_data", rx_data, 8'h80);
        check("sim_latency_ovr", 8'(overrun_err), 8'd0);
      end
    join
    check_frame("sim_80");
    check("sim_80_ovr", 8'(overrun_err), 8'd0);
    consume("sim_80");
    check("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
